// File: rtl/pe_mac_pkg.sv
// pe_mac_pkg
//   Shared definitions for the PE MAC sequencer.
//   - state_t      : sequencer FSM states (3-bit encoding)
//   - N            : default vector length / PE RAM depth (2**L_RAM_SIZE_DFLT)
//   - RES_TIMEOUT  : result word presented after a watchdog timeout
package pe_mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLR   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_ISSUE = 3'd4,
        ST_WAIT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam int L_RAM_SIZE_DFLT = 3;
    localparam int N               = 2 ** L_RAM_SIZE_DFLT;
    localparam int WAIT_MAX_DFLT   = 31;

    localparam logic [15:0] RES_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/pe_mac_seq_watchdog.sv
// pe_mac_watchdog
//   Clear/enable cycle counter with a terminal flag. The count advances on
//   every enabled cycle and saturates at MAX-1; hit is raised on the MAX-th
//   consecutive enabled cycle since the last clear.
// Ports
//   aclk     in   clock
//   aresetn  in   synchronous active-low reset
//   clr      in   return the count to zero
//   en       in   count this cycle
//   hit      out  terminal flag (combinational from count and en)
module pe_mac_watchdog #(
    parameter int MAX = 31
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] TERM = W'(MAX - 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge aclk) begin
        if (!aresetn || clr) begin
            count_reg <= '0;
        end else if (en && !hit) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign hit = en && (count_reg == TERM);

endmodule

// File: rtl/pe_mac_seq.sv
// pe_mac_seq
//   Upstream sequencer for one MAC processing element. Consumes a byte stream
//   of N B-weights (written into the PE RAM) followed by N A-operands (one PE
//   MAC each) and returns the PE's 16-bit dot product on a valid/ready port.
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   s_valid/s_ready/s_data input byte stream (B-weights, then A-operands)
//   res_valid/res_ready/res_data  dot-product result
//   err                    sticky timeout flag (always 0 without PEMAC_TIMEOUT_EN)
//   pe_aresetn             PE accumulator clear (active-low)
//   pe_din/pe_addr/pe_we   PE RAM write port / read address
//   pe_ain/pe_valid        PE A operand and MAC issue strobe
//   pe_dvalid/pe_dout      PE result strobe and accumulated value
// Build option
//   PEMAC_TIMEOUT_EN : enables the WAIT watchdog (pe_mac_watchdog, WAIT_MAX cycles).
module pe_mac_seq
    import pe_mac_pkg::*;
#(
    parameter int L_RAM_SIZE = L_RAM_SIZE_DFLT,
    parameter int WAIT_MAX   = WAIT_MAX_DFLT
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [15:0]           res_data,
    output logic                  err,
    output logic                  pe_aresetn,
    output logic [7:0]            pe_din,
    output logic [L_RAM_SIZE-1:0] pe_addr,
    output logic                  pe_we,
    output logic [7:0]            pe_ain,
    output logic                  pe_valid,
    input  logic                  pe_dvalid,
    input  logic [15:0]           pe_dout
);

    localparam logic [L_RAM_SIZE-1:0] LAST_IDX = '1;
    localparam logic [L_RAM_SIZE-1:0] IDX_ONE  = {{(L_RAM_SIZE-1){1'b0}}, 1'b1};

    if (L_RAM_SIZE < 1 || WAIT_MAX < 2) begin : g_bad_params
        $error("pe_mac_seq: L_RAM_SIZE must be >= 1 and WAIT_MAX >= 2");
    end

    state_t                  state_reg;
    logic [L_RAM_SIZE-1:0]   idx_reg;
    logic                    s_ready_reg;
    logic                    res_valid_reg;
    logic [15:0]             res_data_reg;
    logic                    pe_aresetn_reg;
    logic [7:0]              pe_din_reg;
    logic [L_RAM_SIZE-1:0]   pe_addr_reg;
    logic                    pe_we_reg;
    logic [7:0]              pe_ain_reg;
    logic                    pe_valid_reg;

`ifdef PEMAC_TIMEOUT_EN
    logic err_reg;
    logic wd_hit;

    // Counter runs only while waiting on the PE; any other state re-arms it.
    pe_mac_watchdog #(
        .MAX (WAIT_MAX)
    ) u_watchdog (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (state_reg != ST_WAIT),
        .en      (state_reg == ST_WAIT),
        .hit     (wd_hit)
    );

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            s_ready_reg    <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            pe_aresetn_reg <= 1'b0;
            pe_din_reg     <= '0;
            pe_addr_reg    <= '0;
            pe_we_reg      <= 1'b0;
            pe_ain_reg     <= '0;
            pe_valid_reg   <= 1'b0;
`ifdef PEMAC_TIMEOUT_EN
            err_reg        <= 1'b0;
`endif
        end else begin
            // Write and issue strobes are single-cycle unless re-armed below.
            pe_we_reg    <= 1'b0;
            pe_valid_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    idx_reg        <= '0;
                    s_ready_reg    <= 1'b1;
                    pe_aresetn_reg <= 1'b1;
                    state_reg      <= ST_LOAD;
                end

                ST_LOAD: begin
                    if (s_valid && s_ready_reg) begin
                        pe_we_reg   <= 1'b1;
                        pe_addr_reg <= idx_reg;
                        pe_din_reg  <= s_data;
                        if (idx_reg == LAST_IDX) begin
                            // Last weight: pulse the PE clear during CLR.
                            idx_reg        <= '0;
                            s_ready_reg    <= 1'b0;
                            pe_aresetn_reg <= 1'b0;
                            state_reg      <= ST_CLR;
                        end else begin
                            idx_reg <= idx_reg + IDX_ONE;
                        end
                    end
                end

                ST_CLR: begin
                    idx_reg        <= '0;
                    pe_aresetn_reg <= 1'b1;
                    s_ready_reg    <= 1'b1;
                    state_reg      <= ST_ADDR;
                end

                ST_ADDR: begin
                    if (s_valid && s_ready_reg) begin
                        // Address and operand are presented together with the
                        // issue strobe and held until the PE answers.
                        pe_ain_reg   <= s_data;
                        pe_addr_reg  <= idx_reg;
                        pe_valid_reg <= 1'b1;
                        s_ready_reg  <= 1'b0;
                        state_reg    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    state_reg <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (pe_dvalid) begin
                        if (idx_reg == LAST_IDX) begin
                            res_data_reg  <= pe_dout;
                            res_valid_reg <= 1'b1;
                            state_reg     <= ST_DONE;
                        end else begin
                            idx_reg     <= idx_reg + IDX_ONE;
                            s_ready_reg <= 1'b1;
                            state_reg   <= ST_ADDR;
                        end
                    end
`ifdef PEMAC_TIMEOUT_EN
                    else if (wd_hit) begin
                        err_reg       <= 1'b1;
                        res_data_reg  <= RES_TIMEOUT;
                        res_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
`endif
                end

                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    s_ready_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_reg;
    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    // Gated with aresetn so the PE is held in reset for the whole reset window.
    assign pe_aresetn = pe_aresetn_reg & aresetn;
    assign pe_din     = pe_din_reg;
    assign pe_addr    = pe_addr_reg;
    assign pe_we      = pe_we_reg;
    assign pe_ain     = pe_ain_reg;
    assign pe_valid   = pe_valid_reg;

endmodule

// File: tb/tb_pe_mac_seq.sv
// tb_pe_mac_seq
//   Directed bench for pe_mac_seq with a behavioural PE (registered RAM read,
//   result strobe 15 cycles after issue, accumulator cleared by pe_aresetn).
module tb_pe_mac_seq;
    import pe_mac_pkg::*;

    localparam int NV = N;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        err;
    logic        pe_aresetn;
    logic [7:0]  pe_din;
    logic [2:0]  pe_addr;
    logic        pe_we;
    logic [7:0]  pe_ain;
    logic        pe_valid;
    logic        pe_dvalid;
    logic [15:0] pe_dout;

    always #5 aclk = ~aclk;

    pe_mac_seq #(
        .L_RAM_SIZE (3),
        .WAIT_MAX   (31)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .err        (err),
        .pe_aresetn (pe_aresetn),
        .pe_din     (pe_din),
        .pe_addr    (pe_addr),
        .pe_we      (pe_we),
        .pe_ain     (pe_ain),
        .pe_valid   (pe_valid),
        .pe_dvalid  (pe_dvalid),
        .pe_dout    (pe_dout)
    );

    // ---------------- behavioural PE ----------------
    logic [7:0]  pe_ram [NV];
    logic [7:0]  rd_q = 8'h00;
    logic [15:0] acc = 16'h0000;
    int          pcnt = 0;
    logic        mdv = 1'b0;
    logic        pe_en = 1'b1;
    logic        spur = 1'b0;

    always @(posedge aclk) begin
        if (pe_we) pe_ram[pe_addr] <= pe_din;
        mdv <= 1'b0;
        if (!pe_aresetn) acc <= 16'h0000;
        else if (pcnt == 1) acc <= acc + 16'(rd_q) * 16'(pe_ain);
        if (pe_valid) begin
            rd_q <= pe_ram[pe_addr];
            pcnt <= 1;
        end else if (pcnt == 15) begin
            pcnt <= 0;
            mdv  <= pe_en;
        end else if (pcnt != 0) begin
            pcnt <= pcnt + 1;
        end
    end

    assign pe_dvalid = mdv | spur;
    assign pe_dout   = acc;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] b_vec [NV];
    logic [7:0] a_vec [NV];

    // Monitor: PE-side transactions and s_ready discipline.
    int we_cnt = 0, mac_cnt = 0, pulse_viol = 0, ready_viol = 0;
    int we_base = 0, mac_base = 0;
    bit in_wait = 1'b0, prev_valid = 1'b0;

    always @(negedge aclk) begin
        if ((pe_valid || in_wait || !pe_aresetn) && s_ready) ready_viol++;
        if (pe_we) begin
            if (we_cnt - we_base < NV) begin
                chk_eq("we_addr", 32'(pe_addr), 32'(we_cnt - we_base));
                chk_eq("we_din", 32'(pe_din), 32'(b_vec[we_cnt - we_base]));
            end
            we_cnt++;
        end
        if (pe_valid) begin
            if (mac_cnt - mac_base < NV) begin
                chk_eq("mac_addr", 32'(pe_addr), 32'(mac_cnt - mac_base));
                chk_eq("mac_ain", 32'(pe_ain), 32'(a_vec[mac_cnt - mac_base]));
            end
            if (prev_valid) pulse_viol++;
            mac_cnt++;
        end
        prev_valid = pe_valid;
        if (pe_valid) in_wait = 1'b1;
        else if (pe_dvalid || !pe_aresetn) in_wait = 1'b0;
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0; s_valid = 1'b0; res_ready = 1'b0; spur = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic feed(input int nbytes, input bit toggle, input bit spur_en,
                        input int abort_mac, output bit aborted);
        int k = 0;
        int guard = 0;
        int macs = 0;
        bit ph = 1'b1;
        aborted = 1'b0;
        while (k < nbytes && guard < 3000) begin
            @(negedge aclk);
            guard++;
            if (pe_valid) macs++;
            if (abort_mac != 0 && macs == abort_mac) begin
                s_valid = 1'b0; spur = 1'b0;
                repeat (5) @(negedge aclk);
                aresetn = 1'b0;
                @(negedge aclk);
                chk_eq("rst_s_ready", 32'(s_ready), 0);
                chk_eq("rst_res_valid", 32'(res_valid), 0);
                chk_eq("rst_res_data", 32'(res_data), 0);
                chk_eq("rst_pe_we", 32'(pe_we), 0);
                chk_eq("rst_pe_valid", 32'(pe_valid), 0);
                chk_eq("rst_pe_addr", 32'(pe_addr), 0);
                chk_eq("rst_pe_ain", 32'(pe_ain), 0);
                chk_eq("rst_pe_din", 32'(pe_din), 0);
                chk_eq("rst_pe_aresetn", 32'(pe_aresetn), 0);
                chk_eq("rst_err", 32'(err), 0);
                aresetn = 1'b1;
                aborted = 1'b1;
                return;
            end
            s_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            if (k < NV) s_data = b_vec[k];
            else        s_data = a_vec[k - NV];
            spur = spur_en && s_ready;
            if (s_valid && s_ready) k++;
        end
        chk_eq("feed_bytes", 32'(k), 32'(nbytes));
        @(negedge aclk);
        s_valid = 1'b0; spur = 1'b0;
    endtask

    task automatic get_result(input string tag, input int hold, input logic [15:0] exp);
        int g = 0;
        int unstable = 0, dropped = 0, rdy = 0;
        logic [15:0] first;
        while (!res_valid && g < 3000) begin
            @(negedge aclk);
            g++;
        end
        chk_eq({tag, "_res_valid"}, 32'(res_valid), 1);
        first = res_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            if (res_data !== first) unstable++;
            if (!res_valid) dropped++;
            if (s_ready) rdy++;
        end
        if (hold > 0) begin
            chk_eq({tag, "_stable"}, 32'(unstable), 0);
            chk_eq({tag, "_held"}, 32'(dropped), 0);
            chk_eq({tag, "_no_s_ready"}, 32'(rdy), 0);
        end
        chk_eq({tag, "_res_data"}, 32'(res_data), 32'(exp));
        res_ready = 1'b1;
        @(negedge aclk);
        res_ready = 1'b0;
        chk_eq({tag, "_accepted"}, 32'(res_valid), 0);
    endtask

    task automatic run_vec(input string tag, input bit toggle, input bit spur_en,
                           input int hold, input logic [15:0] exp);
        bit ab;
        int pv0, rv0;
        we_base = we_cnt; mac_base = mac_cnt; pv0 = pulse_viol; rv0 = ready_viol;
        feed(2 * NV, toggle, spur_en, 0, ab);
        get_result(tag, hold, exp);
        chk_eq({tag, "_writes"}, 32'(we_cnt - we_base), 32'(NV));
        chk_eq({tag, "_macs"}, 32'(mac_cnt - mac_base), 32'(NV));
        chk_eq({tag, "_pulse_width"}, 32'(pulse_viol - pv0), 0);
        chk_eq({tag, "_s_ready_low"}, 32'(ready_viol - rv0), 0);
        $display("vector %s done: res_data=%0d expected %0d", tag, res_data, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ab;
        int g;
        int lat;
        int seen_rv, seen_err, seen_rdy;

        for (int i = 0; i < NV; i++) begin
            b_vec[i] = 8'h00;
            a_vec[i] = 8'h00;
        end

        repeat (2) @(negedge aclk);
        chk_eq("reset_s_ready", 32'(s_ready), 0);
        chk_eq("reset_res_valid", 32'(res_valid), 0);
        chk_eq("reset_res_data", 32'(res_data), 0);
        chk_eq("reset_pe_we", 32'(pe_we), 0);
        chk_eq("reset_pe_valid", 32'(pe_valid), 0);
        chk_eq("reset_pe_aresetn", 32'(pe_aresetn), 0);
        chk_eq("reset_err", 32'(err), 0);
        aresetn = 1'b1;

        // 1: B=1..8, A=1 x8, continuous valid
        for (int i = 0; i < NV; i++) begin b_vec[i] = 8'(i + 1); a_vec[i] = 8'd1; end
        run_vec("t1", 1'b0, 1'b0, 0, 16'd36);

        // 2: B=2 x8, A=1..8, valid toggling
        for (int i = 0; i < NV; i++) begin b_vec[i] = 8'd2; a_vec[i] = 8'(i + 1); end
        run_vec("t2", 1'b1, 1'b0, 0, 16'd72);

        // 3: result back-pressure, then a second vector with no carry-over
        for (int i = 0; i < NV; i++) begin b_vec[i] = 8'(i + 1); a_vec[i] = 8'd3; end
        run_vec("t3a", 1'b0, 1'b0, 20, 16'd108);
        for (int i = 0; i < NV; i++) begin b_vec[i] = 8'd1; a_vec[i] = 8'd3; end
        run_vec("t3b", 1'b0, 1'b0, 0, 16'd24);

        // 4: reset during WAIT of MAC 4, then a fresh vector
        for (int i = 0; i < NV; i++) begin b_vec[i] = 8'(i + 1); a_vec[i] = 8'(i + 1); end
        we_base = we_cnt; mac_base = mac_cnt;
        feed(2 * NV, 1'b0, 1'b0, 4, ab);
        chk_eq("t4_aborted", 32'(ab), 1);
        $display("vector t4_abort done: reset applied in WAIT of MAC 4");
        run_vec("t4", 1'b0, 1'b0, 0, 16'd204);

        // 5: spurious pe_dvalid in LOAD and ADDR
        for (int i = 0; i < NV; i++) begin b_vec[i] = 8'd5; a_vec[i] = 8'(i + 1); end
        run_vec("t5", 1'b1, 1'b1, 0, 16'd180);

        // 6: PE never answers
        for (int i = 0; i < NV; i++) begin b_vec[i] = 8'd1; a_vec[i] = 8'd1; end
        pe_en = 1'b0;
        we_base = we_cnt; mac_base = mac_cnt;
        feed(NV + 1, 1'b0, 1'b0, 0, ab);
        g = 0;
        while (!pe_valid && g < 100) begin @(negedge aclk); g++; end
        chk_eq("t6_issue", 32'(pe_valid), 1);
`ifdef PEMAC_TIMEOUT_EN
        lat = 0;
        while (!res_valid && lat < 200) begin @(negedge aclk); lat++; end
        chk_eq("t6_latency", 32'(lat), 32);
        chk_eq("t6_err", 32'(err), 1);
        chk_eq("t6_res_data", 32'(res_data), 32'hFFFF);
        res_ready = 1'b1;
        @(negedge aclk);
        res_ready = 1'b0;
        chk_eq("t6_err_sticky", 32'(err), 1);
        $display("vector t6 done: timeout after %0d cycles, res_data=%0h", lat, res_data);
`else
        lat = 0;
        seen_rv = 0; seen_err = 0; seen_rdy = 0;
        repeat (100) begin
            @(negedge aclk);
            lat++;
            if (res_valid) seen_rv++;
            if (err) seen_err++;
            if (s_ready) seen_rdy++;
        end
        chk_eq("t6_no_result", 32'(seen_rv), 0);
        chk_eq("t6_no_err", 32'(seen_err), 0);
        chk_eq("t6_no_s_ready", 32'(seen_rdy), 0);
        $display("vector t6 done: still waiting after %0d cycles, err=%0d", lat, err);
`endif
        pe_en = 1'b1;
        do_reset();
        chk_eq("t6_err_cleared", 32'(err), 0);
        chk_eq("t6_res_valid_cleared", 32'(res_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
